// File: rtl/ats21_instr_issuer.sv
// rtl/ats21_instr_issuer.sv - dual-channel instruction FIFOs feeding ATS21 as req + two halfword beats
// Empty channels are padded with NOP so both buses always carry a complete instruction.

module ats21_issuer_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [31:0]   din,
    input  logic          rd,
    output logic [31:0]   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic [CW-1:0] count_nx;

    // A push is judged against the full flag at the start of the cycle, even if a pop frees a slot.
    assign push = wr && !full;
    assign head = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        case ({push, rd})
            2'b10:   count_nx = count + CW'(1);
            2'b01:   count_nx = count - CW'(1);
            default: count_nx = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (rd)   rd_ptr <= rd_ptr + AW'(1);
            if (wr && full) ovf <= 1'b1;
            count <= count_nx;
            full  <= (count_nx == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

module ats21_instr_issuer #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_wr,
    input  logic [31:0]   a_instr,
    output logic          a_full,
    output logic [CW-1:0] a_count,
    output logic          a_ovf,
    input  logic          b_wr,
    input  logic [31:0]   b_instr,
    output logic          b_full,
    output logic [CW-1:0] b_count,
    output logic          b_ovf,
    input  logic          ats_ready,
    output logic          req,
    output logic [15:0]   ctrlA,
    output logic [15:0]   ctrlB,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, REQ, HI, LO} state_t;

    state_t      state;
    state_t      state_nx;
    logic        start;
    logic        a_pop;
    logic        b_pop;
    logic [31:0] a_head;
    logic [31:0] b_head;
    logic [31:0] h_a;
    logic [31:0] h_b;

    ats21_issuer_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .wr    (a_wr),
        .din   (a_instr),
        .rd    (a_pop),
        .head  (a_head),
        .count (a_count),
        .full  (a_full),
        .ovf   (a_ovf)
    );

    ats21_issuer_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .wr    (b_wr),
        .din   (b_instr),
        .rd    (b_pop),
        .head  (b_head),
        .count (b_count),
        .full  (b_full),
        .ovf   (b_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            IDLE: begin
                if (ats_ready && (a_count != '0 || b_count != '0)) begin
                    state_nx = REQ;
                    start    = 1'b1;
                end
            end
            REQ:     state_nx = HI;
            HI:      state_nx = LO;
            LO:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Heads are captured on the IDLE->REQ edge so only words already queued join the transfer.
    assign a_pop = start && (a_count != '0);
    assign b_pop = start && (b_count != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_a <= '0;
            h_b <= '0;
        end else if (start) begin
            h_a <= a_pop ? a_head : 32'h0;
            h_b <= b_pop ? b_head : 32'h0;
        end
    end

    // Bus outputs are registered from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            req   <= 1'b0;
            busy  <= 1'b0;
            ctrlA <= '0;
            ctrlB <= '0;
        end else begin
            req  <= (state_nx == REQ);
            busy <= (state_nx != IDLE);
            case (state_nx)
                HI: begin
                    ctrlA <= h_a[31:16];
                    ctrlB <= h_b[31:16];
                end
                LO: begin
                    ctrlA <= h_a[15:0];
                    ctrlB <= h_b[15:0];
                end
                default: begin
                    ctrlA <= '0;
                    ctrlB <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ats21_instr_issuer.sv
// tb/tb_ats21_instr_issuer.sv - vector table, directed corner sequences and randomized model check
module tb_ats21_instr_issuer;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          a_wr = 1'b0;
    logic [31:0]   a_instr = '0;
    logic          a_full;
    logic [CW-1:0] a_count;
    logic          a_ovf;
    logic          b_wr = 1'b0;
    logic [31:0]   b_instr = '0;
    logic          b_full;
    logic [CW-1:0] b_count;
    logic          b_ovf;
    logic          ats_ready = 1'b0;
    logic          req;
    logic [15:0]   ctrlA;
    logic [15:0]   ctrlB;
    logic          busy;

    ats21_instr_issuer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_wr(a_wr), .a_instr(a_instr), .a_full(a_full), .a_count(a_count), .a_ovf(a_ovf),
        .b_wr(b_wr), .b_instr(b_instr), .b_full(b_full), .b_count(b_count), .b_ovf(b_ovf),
        .ats_ready(ats_ready), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: queues of words plus a list of bus beats still to be shown.
    typedef struct { bit r; logic [15:0] a; logic [15:0] b; } beat_t;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    beat_t       beats[$];
    bit          m_req, m_busy, m_aovf, m_bovf;
    logic [15:0] m_ca, m_cb;

    task automatic model_edge(input bit rst_n, input bit aw, input logic [31:0] ai,
                              input bit bw, input logic [31:0] bi, input bit rdy);
        beat_t       bt;
        logic [31:0] ha, hb;
        bit          start, af0, bf0;
        if (!rst_n) begin
            qa.delete(); qb.delete(); beats.delete();
            m_req = 0; m_busy = 0; m_aovf = 0; m_bovf = 0; m_ca = '0; m_cb = '0;
            return;
        end
        af0   = (qa.size() == DEPTH);
        bf0   = (qb.size() == DEPTH);
        start = !m_busy && rdy && (qa.size() > 0 || qb.size() > 0);
        if (start) begin
            ha = (qa.size() > 0) ? qa.pop_front() : 32'h0;
            hb = (qb.size() > 0) ? qb.pop_front() : 32'h0;
            beats.push_back('{1'b1, 16'h0, 16'h0});
            beats.push_back('{1'b0, ha[31:16], hb[31:16]});
            beats.push_back('{1'b0, ha[15:0], hb[15:0]});
        end
        if (aw) begin
            if (af0) m_aovf = 1; else qa.push_back(ai);
        end
        if (bw) begin
            if (bf0) m_bovf = 1; else qb.push_back(bi);
        end
        if (beats.size() > 0) begin
            bt = beats.pop_front();
            m_req = bt.r; m_ca = bt.a; m_cb = bt.b; m_busy = 1;
        end else begin
            m_req = 0; m_ca = '0; m_cb = '0; m_busy = 0;
        end
    endtask

    task automatic check_model(input string name);
        logic [45:0] act, exp;
        act = {req, ctrlA, ctrlB, busy, a_count, b_count, a_full, b_full, a_ovf, b_ovf};
        exp = {m_req, m_ca, m_cb, m_busy, CW'(qa.size()), CW'(qb.size()),
               qa.size() == DEPTH, qb.size() == DEPTH, m_aovf, m_bovf};
        check(name, 64'(act), 64'(exp));
    endtask

    task automatic cycle(input bit rst_n, input bit aw, input logic [31:0] ai,
                         input bit bw, input logic [31:0] bi, input bit rdy, input string name);
        reset = rst_n; a_wr = aw; a_instr = ai; b_wr = bw; b_instr = bi; ats_ready = rdy;
        @(posedge clk);
        model_edge(rst_n, aw, ai, bw, bi, rdy);
        #1;
        check_model(name);
    endtask

    typedef struct {
        bit rst_n; bit aw; logic [31:0] ai; bit bw; logic [31:0] bi; bit rdy;
        bit e_req; logic [15:0] e_ca; logic [15:0] e_cb; bit e_busy; int e_ac; int e_bc;
    } vec_t;
    vec_t vecs[$];

    logic [31:0] pushed[$];
    logic [31:0] got[$];
    int          req_at[$];
    logic [15:0] hi_word;
    bit          prev_req, prev2_req;

    initial begin
        // reset held, then dual push, then A-only with NOP on B
        vecs.push_back('{0,0,32'h0,0,32'h0,0, 0,16'h0,16'h0,0,0,0});
        vecs.push_back('{0,0,32'h0,0,32'h0,0, 0,16'h0,16'h0,0,0,0});
        vecs.push_back('{0,0,32'h0,0,32'h0,0, 0,16'h0,16'h0,0,0,0});
        vecs.push_back('{0,0,32'h0,0,32'h0,0, 0,16'h0,16'h0,0,0,0});
        vecs.push_back('{1,1,32'h1111_4444,1,32'h2222_3333,1, 0,16'h0,16'h0,0,1,1});
        vecs.push_back('{1,0,32'h0,0,32'h0,1, 1,16'h0,16'h0,1,0,0});
        vecs.push_back('{1,0,32'h0,0,32'h0,1, 0,16'h1111,16'h2222,1,0,0});
        vecs.push_back('{1,0,32'h0,0,32'h0,1, 0,16'h4444,16'h3333,1,0,0});
        vecs.push_back('{1,0,32'h0,0,32'h0,1, 0,16'h0,16'h0,0,0,0});
        vecs.push_back('{1,1,32'h2000_0000,0,32'h0,1, 0,16'h0,16'h0,0,1,0});
        vecs.push_back('{1,0,32'h0,0,32'h0,1, 1,16'h0,16'h0,1,0,0});
        vecs.push_back('{1,0,32'h0,0,32'h0,1, 0,16'h2000,16'h0,1,0,0});
        vecs.push_back('{1,0,32'h0,0,32'h0,1, 0,16'h0000,16'h0,1,0,0});
        vecs.push_back('{1,0,32'h0,0,32'h0,1, 0,16'h0,16'h0,0,0,0});
        vecs.push_back('{1,0,32'h0,0,32'h0,1, 0,16'h0,16'h0,0,0,0});

        #1;
        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].aw, vecs[i].ai, vecs[i].bw, vecs[i].bi, vecs[i].rdy,
                  $sformatf("model_vec%0d", i));
            check($sformatf("vec%0d", i),
                  64'({req, ctrlA, ctrlB, busy, a_count, b_count}),
                  64'({vecs[i].e_req, vecs[i].e_ca, vecs[i].e_cb, vecs[i].e_busy,
                       CW'(vecs[i].e_ac), CW'(vecs[i].e_bc)}));
        end
        check("reset_ovf", 64'({a_ovf, b_ovf, a_full, b_full}), 64'(0));

        // ready low queues three words, raising ready issues them every 4 cycles in order
        pushed.delete(); got.delete(); req_at.delete();
        for (int i = 0; i < 3; i++) begin
            pushed.push_back($urandom | 32'h1);
            cycle(1, 1, pushed[i], 0, 0, 0, "t4_push");
        end
        cycle(1, 0, 0, 0, 0, 0, "t4_hold");
        check("t4_count", 64'({req, a_count}), 64'({1'b0, CW'(3)}));
        prev_req = 0; prev2_req = 0; hi_word = '0;
        for (int c = 0; c < 16; c++) begin
            cycle(1, 0, 0, 0, 0, 1, "t4_run");
            if (req) req_at.push_back(c);
            if (prev_req) hi_word = ctrlA;
            if (prev2_req) got.push_back({hi_word, ctrlA});
            prev2_req = prev_req; prev_req = req;
        end
        check("t4_nreq", 64'(req_at.size()), 64'(3));
        if (req_at.size() == 3) begin
            check("t4_gap1", 64'(req_at[1] - req_at[0]), 64'(4));
            check("t4_gap2", 64'(req_at[2] - req_at[1]), 64'(4));
        end
        check("t4_nwords", 64'(got.size()), 64'(3));
        for (int i = 0; i < 3 && i < got.size(); i++) check("t4_order", 64'(got[i]), 64'(pushed[i]));

        // fill A to DEPTH, overflow with one extra word, drain and confirm it is gone
        cycle(0, 0, 0, 0, 0, 0, "t5_reset");
        pushed.delete(); got.delete();
        for (int i = 0; i < DEPTH; i++) begin
            pushed.push_back(($urandom & 32'h7FFF_FFFF) | 32'h1);
            cycle(1, 1, pushed[i], 0, 0, 0, "t5_fill");
        end
        check("t5_full", 64'({a_full, a_ovf}), 64'(2'b10));
        cycle(1, 1, 32'hDEAD_BEEF, 0, 0, 0, "t5_extra");
        check("t5_ovf", 64'({a_full, a_ovf, a_count}), 64'({2'b11, CW'(DEPTH)}));
        prev_req = 0; prev2_req = 0;
        for (int c = 0; c < 4 * DEPTH + 4; c++) begin
            cycle(1, 0, 0, 0, 0, 1, "t5_drain");
            if (prev_req) hi_word = ctrlA;
            if (prev2_req) got.push_back({hi_word, ctrlA});
            prev2_req = prev_req; prev_req = req;
        end
        check("t5_nwords", 64'(got.size()), 64'(DEPTH));
        for (int i = 0; i < DEPTH && i < got.size(); i++) check("t5_word", 64'(got[i]), 64'(pushed[i]));
        check("t5_ovf_sticky", 64'({a_ovf, a_count}), 64'({1'b1, CW'(0)}));

        // reset during HI abandons the transfer: no LO beat afterwards
        cycle(0, 0, 0, 0, 0, 0, "t6_reset");
        cycle(1, 1, 32'hABCD_1234, 1, 32'h5678_EF00, 1, "t6_push");
        cycle(1, 0, 0, 0, 0, 1, "t6_req");
        cycle(1, 0, 0, 0, 0, 1, "t6_hi");
        check("t6_hi_bus", 64'({ctrlA, ctrlB}), 64'({16'hABCD, 16'h5678}));
        cycle(0, 0, 0, 0, 0, 1, "t6_rst");
        check("t6_after_rst", 64'({req, ctrlA, ctrlB, busy, a_count, b_count}), 64'(0));
        for (int c = 0; c < 3; c++) begin
            cycle(1, 0, 0, 0, 0, 1, "t6_idle");
            check("t6_no_lo", 64'({req, ctrlA, ctrlB, busy}), 64'(0));
        end

        // randomized traffic against the model, with occasional resets
        for (int c = 0; c < 2500; c++) begin
            cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) == 0), $urandom,
                  ($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 3) != 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
